// File: rtl/forwarding_unit.sv
// forwarding_unit
//   Responder for the register_read forwarding lookup. Writeback results are
//   held in a shallow age-ordered bypass buffer until the register file can
//   return them. Two source lookups are answered combinationally.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   wb_valid/wb_preg/wb_val       live writeback ports (port i at slice i)
//   flush                         drops all buffered results at the next edge
//   src1_reg, src2_reg            lookup pregs
//   src1_fwrd_hit, src2_fwrd_hit  lookup hit flags
//   src1_val, src2_val            forwarded values (0 on miss)
//   occupancy                     registered count of valid buffered entries
module forwarding_unit #(
  parameter int NUM_PREGS = 64,
  parameter int DATA_W    = 32,
  parameter int WB_PORTS  = 2,
  parameter int DEPTH     = 2,
  localparam int PREG_W   = $clog2(NUM_PREGS),
  localparam int OCC_W    = $clog2(DEPTH*WB_PORTS+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_preg,
  input  logic [WB_PORTS*DATA_W-1:0] wb_val,
  input  logic                       flush,
  input  logic [PREG_W-1:0]          src1_reg,
  input  logic [PREG_W-1:0]          src2_reg,
  output logic                       src1_fwrd_hit,
  output logic                       src2_fwrd_hit,
  output logic [DATA_W-1:0]          src1_val,
  output logic [DATA_W-1:0]          src2_val,
  output logic [OCC_W-1:0]           occupancy
);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [DATA_W-1:0] data_t;

  // Stage 0 is the youngest buffered age, stage DEPTH-1 the oldest.
  logic  [DEPTH-1:0][WB_PORTS-1:0] st_valid, nxt_valid;
  preg_t [DEPTH-1:0][WB_PORTS-1:0] st_preg,  nxt_preg;
  data_t [DEPTH-1:0][WB_PORTS-1:0] st_val,   nxt_val;
  logic  [OCC_W-1:0]               nxt_occ;
  logic  [WB_PORTS-1:0]            live_valid;

  // preg 0 is architecturally constant, so it is neither forwarded nor kept.
  always_comb begin
    live_valid = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      live_valid[p] = wb_valid[p] && (wb_preg[p*PREG_W +: PREG_W] != '0);
    end
  end

  always_comb begin
    nxt_valid = st_valid;
    nxt_preg  = st_preg;
    nxt_val   = st_val;
    nxt_occ   = '0;
    for (int k = DEPTH-1; k > 0; k--) begin
      nxt_valid[k] = st_valid[k-1];
      nxt_preg[k]  = st_preg[k-1];
      nxt_val[k]   = st_val[k-1];
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      nxt_valid[0][p] = live_valid[p];
      nxt_preg[0][p]  = wb_preg[p*PREG_W +: PREG_W];
      nxt_val[0][p]   = wb_val[p*DATA_W +: DATA_W];
    end
    // Flush discards everything, including the results arriving this cycle.
    if (flush) begin
      nxt_valid = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        nxt_occ = nxt_occ + OCC_W'(nxt_valid[k][p]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid  <= '0;
      st_preg   <= '0;
      st_val    <= '0;
      occupancy <= '0;
    end else begin
      st_valid  <= nxt_valid;
      st_preg   <= nxt_preg;
      st_val    <= nxt_val;
      occupancy <= nxt_occ;
    end
  end

  // Youngest match wins: live ports first, then stage 0 upward; lowest port
  // index wins within an age. Returns {hit, value}.
  function automatic logic [DATA_W:0] lookup(input preg_t src);
    logic  hit;
    data_t val;
    hit = 1'b0;
    val = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (!hit && live_valid[p] && wb_preg[p*PREG_W +: PREG_W] == src) begin
        hit = 1'b1;
        val = wb_val[p*DATA_W +: DATA_W];
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (!hit && st_valid[k][p] && st_preg[k][p] == src && src != '0) begin
          hit = 1'b1;
          val = st_val[k][p];
        end
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    {src1_fwrd_hit, src1_val} = lookup(src1_reg);
    {src2_fwrd_hit, src2_val} = lookup(src2_reg);
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: expected lookups come from a log of captured
// writes tagged with their capture cycle, queued per cycle and compared at
// the falling edge.
module tb_forwarding_unit;
  localparam int PREG_W   = 6;
  localparam int DATA_W   = 32;
  localparam int WB_PORTS = 2;
  localparam int DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  wb_valid = '0;
  logic [11:0] wb_preg = '0;
  logic [63:0] wb_val = '0;
  logic [5:0]  src1_reg = '0, src2_reg = '0;
  logic        src1_fwrd_hit, src2_fwrd_hit;
  logic [31:0] src1_val, src2_val;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  forwarding_unit #(.NUM_PREGS(64), .DATA_W(DATA_W), .WB_PORTS(WB_PORTS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_val(wb_val),
    .flush(flush), .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_fwrd_hit(src1_fwrd_hit), .src2_fwrd_hit(src2_fwrd_hit),
    .src1_val(src1_val), .src2_val(src2_val), .occupancy(occupancy)
  );

  typedef struct {
    logic        hit1;
    logic [31:0] val1;
    logic        hit2;
    logic [31:0] val2;
    logic [2:0]  occ;
    string       tag;
  } exp_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [5:0]  preg;
    logic [31:0] val;
  } rec_t;

  exp_t sb_q[$];
  rec_t log_q[$];
  int   cyc = 0;
  int   clear_cyc = -1;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit rec_live(input rec_t r);
    return (r.cyc >= cyc - DEPTH) && (r.cyc < cyc) && (r.cyc > clear_cyc);
  endfunction

  function automatic void model_lookup(input logic [5:0] src, input logic [1:0] wv,
                                       input logic [11:0] wp, input logic [63:0] wvl,
                                       output logic hit, output logic [31:0] val);
    int best_c;
    int best_p;
    hit = 1'b0;
    val = '0;
    best_c = -1;
    best_p = 0;
    if (src == 6'd0) return;
    for (int p = WB_PORTS-1; p >= 0; p--) begin
      if (wv[p] && wp[p*PREG_W +: PREG_W] == src) begin
        hit = 1'b1;
        val = wvl[p*DATA_W +: DATA_W];
      end
    end
    if (hit) return;
    foreach (log_q[i]) begin
      if (rec_live(log_q[i]) && log_q[i].preg == src &&
          (!hit || log_q[i].cyc > best_c || (log_q[i].cyc == best_c && log_q[i].port < best_p))) begin
        hit = 1'b1;
        val = log_q[i].val;
        best_c = log_q[i].cyc;
        best_p = log_q[i].port;
      end
    end
  endfunction

  task automatic step(input string tag, input logic r, input logic fl, input logic [1:0] wv,
                      input logic [5:0] p0, input logic [31:0] v0,
                      input logic [5:0] p1, input logic [31:0] v1,
                      input logic [5:0] s1, input logic [5:0] s2);
    exp_t e;
    rec_t rc;
    int   occ;
    logic [11:0] wp;
    logic [63:0] wvl;
    wp  = {p1, p0};
    wvl = {v1, v0};
    @(posedge clk);
    #1;
    rst = r; flush = fl; wb_valid = wv; wb_preg = wp; wb_val = wvl;
    src1_reg = s1; src2_reg = s2;
    if (r) clear_cyc = cyc;
    while (log_q.size() > 0 && log_q[0].cyc < cyc - DEPTH) void'(log_q.pop_front());
    model_lookup(s1, wv, wp, wvl, e.hit1, e.val1);
    model_lookup(s2, wv, wp, wvl, e.hit2, e.val2);
    occ = 0;
    foreach (log_q[i]) if (rec_live(log_q[i])) occ++;
    e.occ = occ[2:0];
    e.tag = tag;
    sb_q.push_back(e);
    if (!r && !fl) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wv[p] && wp[p*PREG_W +: PREG_W] != 6'd0) begin
          rc.cyc = cyc; rc.port = p; rc.preg = wp[p*PREG_W +: PREG_W]; rc.val = wvl[p*DATA_W +: DATA_W];
          log_q.push_back(rc);
        end
      end
    end
    if (fl) clear_cyc = cyc;
    cyc++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, "/hit1"}, 32'(src1_fwrd_hit), 32'(e.hit1));
      check_val({e.tag, "/val1"}, src1_val, e.val1);
      check_val({e.tag, "/hit2"}, 32'(src2_fwrd_hit), 32'(e.hit2));
      check_val({e.tag, "/val2"}, src2_val, e.val2);
      check_val({e.tag, "/occ"},  32'(occupancy), 32'(e.occ));
    end
  end

  initial begin
    // Reset held with both writeback ports pending.
    step("rst_a", 1, 0, 2'b11, 6'd1, 32'h1111_0001, 6'd2, 32'h1111_0002, 6'd1, 6'd2);
    step("rst_b", 1, 0, 2'b11, 6'd1, 32'h1111_0001, 6'd2, 32'h1111_0002, 6'd3, 6'd4);
    step("rst_c", 0, 0, 2'b00, 6'd0, 32'h0,         6'd0, 32'h0,         6'd1, 6'd2);
    // Live bypass.
    step("live",  0, 0, 2'b01, 6'd5, 32'hAAAA_AAAA, 6'd0, 32'h0, 6'd5, 6'd0);
    // Aging of preg 7 across DEPTH cycles.
    step("age0",  0, 0, 2'b01, 6'd7, 32'hDEAD_BEEF, 6'd0, 32'h0, 6'd7, 6'd5);
    step("age1",  0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd7, 6'd5);
    step("age2",  0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd7, 6'd5);
    step("age3",  0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd7, 6'd7);
    // Shadowing and same-cycle tie on preg 9.
    step("shd0",  0, 0, 2'b01, 6'd9, 32'h1111_1111, 6'd0, 32'h0, 6'd0, 6'd9);
    step("shd1",  0, 0, 2'b01, 6'd9, 32'h2222_2222, 6'd0, 32'h0, 6'd0, 6'd9);
    step("shd2",  0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd9, 6'd9);
    step("tie0",  0, 0, 2'b11, 6'd9, 32'h3333_3333, 6'd9, 32'h4444_4444, 6'd9, 6'd9);
    step("tie1",  0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd9, 6'd9);
    step("tie2",  0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd9, 6'd9);
    // Flush.
    step("fl0",   0, 0, 2'b11, 6'd3, 32'h3030_3030, 6'd4, 32'h4040_4040, 6'd3, 6'd4);
    step("fl1",   0, 1, 2'b01, 6'd6, 32'hCAFE_BABE, 6'd0, 32'h0, 6'd6, 6'd3);
    step("fl2",   0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd3, 6'd4);
    step("fl3",   0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd6, 6'd6);
    // preg 0.
    step("z0",    0, 0, 2'b01, 6'd0, 32'hFFFF_FFFF, 6'd0, 32'h0, 6'd0, 6'd0);
    step("z1",    0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 6'd0);
    // Reset mid-stream.
    step("mr0",   0, 0, 2'b11, 6'd10, 32'hA0A0_A0A0, 6'd11, 32'hB1B1_B1B1, 6'd0, 6'd0);
    step("mr1",   1, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd10, 6'd11);
    step("mr2",   0, 0, 2'b01, 6'd12, 32'h1212_1212, 6'd0, 32'h0, 6'd10, 6'd11);
    step("mr3",   0, 0, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd12, 6'd10);
    // Random traffic over a small preg range to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)),
           6'($urandom_range(0, 7)), $urandom, 6'($urandom_range(0, 7)), $urandom,
           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check_val("drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
